// File: rtl/risc_pkg.sv
// Shared definitions for the memory arbiter: FSM states, owner encoding and
// default bus widths.
package risc_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 16;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdWait,
        StAck
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the requester that was
// not served last wins.
module rr_arb2
    import risc_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        if (req[OWN_CPU] && req[OWN_LDR]) begin
            grant_id = ~last_owner;
        end else begin
            grant_id = req[OWN_LDR] ? OWN_LDR : OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port memory between the CPU and the program loader,
// sequencing one write or synchronous read per grant.
module mem_arbiter
    import risc_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    localparam logic [1:0] CntLast = 2'(RD_LAT - 1);

    arb_state_e    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic          last_owner_q;
    logic          owner_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ldr_rdata_q;
    logic          grant_valid;
    logic          grant_id;
    logic          load;
    logic          capture;

    rr_arb2 u_rr_arb2 (
        .req         ({ldr_req, cpu_req}),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    load    = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = 2'd0;
                state_d = we_q ? StAck : StRdWait;
            end
            StRdWait: begin
                // Read data lands on the last wait cycle; grab it on that edge.
                if (cnt_q == CntLast) begin
                    capture = 1'b1;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            last_owner_q <= OWN_LDR;
            owner_q      <= OWN_CPU;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                addr_q       <= (grant_id == OWN_LDR) ? ldr_addr  : cpu_addr;
                wdata_q      <= (grant_id == OWN_LDR) ? ldr_wdata : cpu_wdata;
                we_q         <= (grant_id == OWN_LDR) ? ldr_we    : cpu_we;
                last_owner_q <= grant_id;
                owner_q      <= grant_id;
            end
            if (capture) begin
                if (owner_q == OWN_LDR) begin
                    ldr_rdata_q <= mem_rdata;
                end else begin
                    cpu_rdata_q <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        mem_en    = (state_q == StIssue);
        mem_we    = mem_en & we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_ack   = (state_q == StAck) && (owner_q == OWN_CPU);
        ldr_ack   = (state_q == StAck) && (owner_q == OWN_LDR);
        cpu_stall = cpu_req & ~cpu_ack;
        cpu_rdata = cpu_rdata_q;
        ldr_rdata = ldr_rdata_q;
        owner     = owner_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances (RD_LAT 1 and 3) share one
// memory model; sel chooses which instance is driven and observed.
module tb_mem_arbiter;
    import risc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;

    logic        cpu_ack_v [2], ldr_ack_v [2], cpu_stall_v [2];
    logic        mem_en_v [2], mem_we_v [2], owner_v [2];
    logic [15:0] cpu_rdata_v [2], ldr_rdata_v [2], mem_addr_v [2], mem_wdata_v [2];

    logic        cpu_ack, ldr_ack, cpu_stall, mem_en, mem_we, owner;
    logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;

    assign cpu_ack   = cpu_ack_v[sel];
    assign ldr_ack   = ldr_ack_v[sel];
    assign cpu_stall = cpu_stall_v[sel];
    assign mem_en    = mem_en_v[sel];
    assign mem_we    = mem_we_v[sel];
    assign owner     = owner_v[sel];
    assign cpu_rdata = cpu_rdata_v[sel];
    assign ldr_rdata = ldr_rdata_v[sel];
    assign mem_addr  = mem_addr_v[sel];
    assign mem_wdata = mem_wdata_v[sel];

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req & ~sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack_v[0]), .cpu_rdata(cpu_rdata_v[0]),
        .cpu_stall(cpu_stall_v[0]),
        .ldr_req(ldr_req & ~sel), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack_v[0]), .ldr_rdata(ldr_rdata_v[0]),
        .mem_en(mem_en_v[0]), .mem_we(mem_we_v[0]), .mem_addr(mem_addr_v[0]),
        .mem_wdata(mem_wdata_v[0]), .mem_rdata(mem_rdata), .owner(owner_v[0])
    );

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req & sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack_v[1]), .cpu_rdata(cpu_rdata_v[1]),
        .cpu_stall(cpu_stall_v[1]),
        .ldr_req(ldr_req & sel), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack_v[1]), .ldr_rdata(ldr_rdata_v[1]),
        .mem_en(mem_en_v[1]), .mem_we(mem_we_v[1]), .mem_addr(mem_addr_v[1]),
        .mem_wdata(mem_wdata_v[1]), .mem_rdata(mem_rdata), .owner(owner_v[1])
    );

    // Memory model: read data appears 1 or 3 cycles after the mem_en cycle.
    logic [15:0] mem [256];
    logic [15:0] rd_pipe [3];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            rd_pipe[0] <= mem[mem_addr[7:0]];
        end
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign mem_rdata = sel ? rd_pipe[2] : rd_pipe[0];

    typedef struct packed {
        logic        id;
        logic        rd;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q [$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Monitor: every ack must match the next expected transaction.
    always @(negedge clk) begin
        exp_t e;
        if (reset && (cpu_ack || ldr_ack)) begin
            if (exp_q.size() == 0) begin
                check("unexpected ack", {30'b0, ldr_ack, cpu_ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("ack id", {31'b0, ldr_ack}, {31'b0, e.id});
                check("ack owner", {31'b0, owner}, {31'b0, e.id});
                if (e.rd) check("ack rdata", e.id ? ldr_rdata : cpu_rdata, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one handshake on a port; lat is ack cycle minus request cycle, -1 on timeout.
    task automatic txn(input logic port, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, output int lat);
        if (port == OWN_CPU) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (port == OWN_CPU ? cpu_ack : ldr_ack) begin
                lat = c;
                break;
            end
            step();
        end
        step();
        if (port == OWN_CPU) cpu_req = 1'b0;
        else ldr_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, k, last;
        sel = 1'b0; reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        repeat (2) step();
        @(negedge clk);
        check("rst owner", {31'b0, owner}, 32'd0);
        check("rst mem_en", {31'b0, mem_en}, 32'd0);
        check("rst cpu_ack", {31'b0, cpu_ack}, 32'd0);
        check("rst cpu_rdata", cpu_rdata, 32'd0);
        step();
        reset = 1'b1;
        step();

        // CPU write with cycle-exact timing
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF;
        exp_q.push_back('{id: OWN_CPU, rd: 1'b0, data: 16'h0});
        @(negedge clk);
        check("wr T stall", {31'b0, cpu_stall}, 32'd1);
        check("wr T mem_en", {31'b0, mem_en}, 32'd0);
        step(); @(negedge clk);
        check("wr T+1 mem_en", {31'b0, mem_en}, 32'd1);
        check("wr T+1 mem_we", {31'b0, mem_we}, 32'd1);
        check("wr T+1 mem_addr", mem_addr, 32'h0010);
        check("wr T+1 mem_wdata", mem_wdata, 32'hBEEF);
        check("wr T+1 stall", {31'b0, cpu_stall}, 32'd1);
        step(); @(negedge clk);
        check("wr T+2 ack", {31'b0, cpu_ack}, 32'd1);
        check("wr T+2 stall", {31'b0, cpu_stall}, 32'd0);
        step();
        cpu_req = 0;
        @(negedge clk);
        check("wr idle mem_en", {31'b0, mem_en}, 32'd0);
        step();

        // CPU read, RD_LAT=1
        exp_q.push_back('{id: OWN_CPU, rd: 1'b1, data: 16'hBEEF});
        txn(OWN_CPU, 1'b0, 16'h0010, 16'h0, lat);
        check("rd1 latency", lat, 32'd3);
        check("rd1 ldr_rdata", ldr_rdata, 32'd0);

        // Both requesters held from reset: strict alternation
        reset = 1'b0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'hAAAA;
        ldr_req = 1; ldr_we = 1; ldr_addr = 16'h0021; ldr_wdata = 16'h5555;
        for (int i = 0; i < 4; i++) exp_q.push_back('{id: i[0], rd: 1'b0, data: 16'h0});
        step();
        reset = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cpu_ack || ldr_ack) n++;
            if (n == 4) break;
            step();
        end
        step();
        cpu_req = 0; ldr_req = 0;
        check("rr ack count", n, 32'd4);
        check("rr mem cpu", mem[8'h20], 32'hAAAA);
        check("rr mem ldr", mem[8'h21], 32'h5555);
        step();

        // Loader back-to-back writes
        ldr_req = 1; ldr_we = 1; ldr_wdata = 16'h1111; ldr_addr = 16'h0;
        for (int i = 0; i < 4; i++) exp_q.push_back('{id: OWN_LDR, rd: 1'b0, data: 16'h0});
        k = 0; last = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ldr_ack) begin
                if (k > 0) check("ldr ack period", c - last, 32'd3);
                last = c;
                k++;
                if (k == 4) break;
            end
            step();
            ldr_addr = 16'(k);
        end
        step();
        ldr_req = 0;
        check("ldr ack count", k, 32'd4);
        for (int a = 0; a < 4; a++) check("ldr mem word", mem[a], 32'h1111);
        step();

        // Reset during RD_WAIT of a loader read: no ack, state cleared
        ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0010;
        step(); step();
        @(negedge clk);
        reset = 1'b0;
        ldr_req = 0;
        #1;
        check("abort ldr_ack", {31'b0, ldr_ack}, 32'd0);
        check("abort mem_en", {31'b0, mem_en}, 32'd0);
        check("abort ldr_rdata", ldr_rdata, 32'd0);
        check("abort owner", {31'b0, owner}, 32'd0);
        step(); step();
        reset = 1'b1;
        repeat (3) step();
        exp_q.push_back('{id: OWN_CPU, rd: 1'b1, data: 16'hBEEF});
        txn(OWN_CPU, 1'b0, 16'h0010, 16'h0, lat);
        check("post-abort latency", lat, 32'd3);

        // RD_LAT=3 instance, with a one-cycle loader pulse that must be ignored
        sel = 1'b1;
        step();
        exp_q.push_back('{id: OWN_CPU, rd: 1'b1, data: 16'hBEEF});
        fork
            txn(OWN_CPU, 1'b0, 16'h0010, 16'h0, lat);
            begin
                step(); step();
                ldr_req = 1; ldr_we = 0; ldr_addr = 16'h0010;
                step();
                ldr_req = 0;
            end
        join
        check("rd3 latency", lat, 32'd5);
        repeat (6) step();
        check("rd3 ldr_rdata", ldr_rdata, 32'd0);
        check("rd3 owner", {31'b0, owner}, 32'd0);

        check("queue drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
